// File: rtl/aes_enc_seq.sv
// Iterative AES encryptor (128/192/256-bit keys), one round per cycle.
// The expanded key schedule is kept and reused until a new key is requested.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x,
                                      input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // multiplicative inverse as x^254 (maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] e;
    e = gmul(x, x);
    e = gmul(e, x);
    e = gmul(e, e);
    e = gmul(e, x);
    e = gmul(e, e);
    e = gmul(e, x);
    e = gmul(e, e);
    e = gmul(e, x);
    e = gmul(e, e);
    e = gmul(e, x);
    e = gmul(e, e);
    e = gmul(e, x);
    e = gmul(e, e);
    return e;
  endfunction

  logic [7:0] b;

  always_comb begin
    b = ginv(a);
    y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
      ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end
endmodule

module aes_enc_seq #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             key_new,
  input  logic [127:0]     data_in,
  input  logic [Nk*32-1:0] key_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     data_encrypted,
  output logic             busy
);
  localparam int NW  = 4 * (Nr + 1);
  localparam int WCW = $clog2(NW);
  localparam int RW  = $clog2(Nr + 1);

  typedef enum logic [2:0] {
    IDLE, KEXP, INIT, ROUND, FINAL, OUT
  } st_t;

  st_t            st;
  logic [127:0]   s;
  logic [31:0]    w [NW];
  logic [WCW-1:0] wcnt;
  logic [2:0]     kpos;
  logic [7:0]     rcon;
  logic [RW-1:0]  rnd;
  logic           key_loaded;

  logic           accept;
  logic           need_exp;
  logic [31:0]    prev;
  logic [31:0]    sw;
  logic [31:0]    temp;
  logic [31:0]    kword;
  logic [WCW-1:0] rb;
  logic [127:0]   rk;
  logic [7:0]     sb [16];
  logic [127:0]   srv;
  logic [127:0]   mc;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  assign accept   = in_valid && in_ready;
  assign need_exp = key_new || !key_loaded;

  assign prev = w[wcnt - WCW'(1)];

  for (genvar k = 0; k < 4; k++) begin : g_ksb
    aes_sbox u_sb (.a(prev[8*k +: 8]), .y(sw[8*k +: 8]));
  end

  // SubWord commutes with RotWord, so one S-box row serves both cases
  always_comb begin
    temp = prev;
    if (kpos == 3'd0)
      temp = {sw[23:0], sw[31:24]} ^ {rcon, 24'h0};
    else if (Nk == 8 && kpos == 3'd4)
      temp = sw;
  end

  assign kword = w[wcnt - WCW'(Nk)] ^ temp;

  assign rb = WCW'({rnd, 2'b00});
  assign rk = {w[rb], w[rb + WCW'(1)],
               w[rb + WCW'(2)], w[rb + WCW'(3)]};

  for (genvar b = 0; b < 16; b++) begin : g_ssb
    aes_sbox u_sb (.a(s[127-8*b -: 8]), .y(sb[b]));
  end

  always_comb begin
    srv = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        srv[127-8*(r+4*c) -: 8] = sb[r + 4*((c + r) % 4)];
  end

  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++)
      mc[127-32*c -: 32] = mixcol(srv[127-32*c -: 32]);
  end

  always_ff @(posedge clk) begin
    if (st == IDLE && accept && need_exp) begin
      for (int k = 0; k < Nk; k++)
        w[k] <= key_in[32*(Nk-1-k) +: 32];
    end else if (st == KEXP) begin
      w[wcnt] <= kword;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st             <= IDLE;
      s              <= '0;
      wcnt           <= '0;
      kpos           <= '0;
      rcon           <= 8'h01;
      rnd            <= '0;
      key_loaded     <= 1'b0;
      in_ready       <= 1'b1;
      busy           <= 1'b0;
      out_valid      <= 1'b0;
      data_encrypted <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (accept) begin
            s        <= data_in;
            rnd      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (need_exp) begin
              st   <= KEXP;
              wcnt <= WCW'(Nk);
              kpos <= '0;
              rcon <= 8'h01;
            end else begin
              st <= INIT;
            end
          end
        end
        KEXP: begin
          wcnt <= wcnt + WCW'(1);
          kpos <= (kpos == 3'(Nk - 1)) ? 3'd0 : kpos + 3'd1;
          if (kpos == 3'd0) rcon <= xt(rcon);
          if (wcnt == WCW'(NW - 1)) begin
            st         <= INIT;
            key_loaded <= 1'b1;
          end
        end
        INIT: begin
          s   <= s ^ rk;
          rnd <= RW'(1);
          st  <= (Nr == 1) ? FINAL : ROUND;
        end
        ROUND: begin
          s   <= mc ^ rk;
          rnd <= rnd + RW'(1);
          if (rnd == RW'(Nr - 1)) st <= FINAL;
        end
        FINAL: begin
          s              <= srv ^ rk;
          data_encrypted <= srv ^ rk;
          out_valid      <= 1'b1;
          st             <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_enc_seq.sv
// Bench for aes_enc_seq: all three key sizes against a byte-level AES model.
// Directed vectors, hold/abort scenarios, then random plaintexts and keys.
module tb_aes_enc_seq;
  logic         clk;
  logic         rst;
  logic [2:0]   iv;
  logic [2:0]   ir;
  logic [2:0]   ov;
  logic [2:0]   bz;
  logic         key_new;
  logic         out_ready;
  logic [127:0] data_in;
  logic [255:0] key;
  logic [127:0] de [3];

  int           errors;
  int           checks;
  logic [127:0] exp_ct;
  int           exp_lat;
  logic [2:0]   kl;
  logic [255:0] kkey [3];
  logic [7:0]   sbox_t [256];
  logic [7:0]   rcon_t [10];

  aes_enc_seq #(.Nk(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .key_new(key_new), .data_in(data_in), .key_in(key[255:128]),
    .out_valid(ov[0]), .out_ready(out_ready),
    .data_encrypted(de[0]), .busy(bz[0]));

  aes_enc_seq #(.Nk(6)) u_d6 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .key_new(key_new), .data_in(data_in), .key_in(key[255:64]),
    .out_valid(ov[1]), .out_ready(out_ready),
    .data_encrypted(de[1]), .busy(bz[1]));

  aes_enc_seq #(.Nk(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .key_new(key_new), .data_in(data_in), .key_in(key[255:0]),
    .out_valid(ov[2]), .out_ready(out_ready),
    .data_encrypted(de[2]), .busy(bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_t[v[31:24]], sbox_t[v[23:16]],
            sbox_t[v[15:8]], sbox_t[v[7:0]]};
  endfunction

  function automatic logic [127:0] ref_enc(input int nk,
                                           input logic [255:0] k,
                                           input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   s [4][4];
    logic [7:0]   u [4][4];
    logic [127:0] r;
    int           nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk-1], 24'h0};
      else if (nk > 6 && i % nk == 4)
        t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int b = 0; b < 16; b++)
      s[b%4][b/4] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 4; i++)
        for (int c = 0; c < 4; c++)
          u[i][c] = sbox_t[s[i][(c+i)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rd < nr) begin
          s[0][c] = gm(u[0][c], 2) ^ gm(u[1][c], 3) ^ u[2][c] ^ u[3][c];
          s[1][c] = u[0][c] ^ gm(u[1][c], 2) ^ gm(u[2][c], 3) ^ u[3][c];
          s[2][c] = u[0][c] ^ u[1][c] ^ gm(u[2][c], 2) ^ gm(u[3][c], 3);
          s[3][c] = gm(u[0][c], 3) ^ u[1][c] ^ u[2][c] ^ gm(u[3][c], 2);
        end else begin
          for (int i = 0; i < 4; i++) s[i][c] = u[i][c];
        end
      end
      for (int i = 0; i < 4; i++)
        for (int c = 0; c < 4; c++)
          s[i][c] ^= w[4*rd+c][31-8*i -: 8];
    end
    for (int b = 0; b < 16; b++) r[127-8*b -: 8] = s[b%4][b/4];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic start(input int d, input logic kn,
                       input logic [127:0] pt);
    int n;
    int nk;
    logic exp_key;
    logic [255:0] uk;
    n = 0;
    while (!ir[d] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    nk = 4 + 2*d;
    exp_key = kn || !kl[d];
    uk = exp_key ? key : kkey[d];
    exp_lat = (exp_key ? 4*(nk+7) - nk : 0) + nk + 7;
    exp_ct = ref_enc(nk, uk, pt);
    key_new = kn;
    data_in = pt;
    iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    kl[d] = 1'b1;
    kkey[d] = uk;
  endtask

  task automatic wait_out(input int d, input logic corrupt);
    int n;
    logic [255:0] save;
    n = 0;
    save = key;
    while (!ov[d] && n < 300) begin
      if (corrupt) key = {rnd128(), rnd128()};
      data_in = rnd128();
      @(posedge clk); #1;
      n++;
    end
    key = save;
    chk("latency", 128'(n), 128'(exp_lat));
    chk("ciphertext", de[d], exp_ct);
    chk("busy_in_out", 128'(bz[d]), 128'(1));
  endtask

  task automatic drain(input int d);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_ov", 128'(ov[d]), 128'(0));
    chk("drain_ready", 128'(ir[d]), 128'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ready", 128'(ir), 128'(3'b111));
    chk("rst_ov", 128'(ov), 128'(0));
    chk("rst_busy", 128'(bz), 128'(0));
    chk("rst_data", de[0], 128'(0));
    kl = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [127:0] pt0;
  logic [127:0] pt2;

  initial begin
    logic [7:0] p;
    logic [7:0] q;
    errors = 0;
    checks = 0;
    rcon_t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      sbox_t[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
                ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;

    rst = 1'b1;
    iv = '0;
    kl = '0;
    key_new = 1'b0;
    out_ready = 1'b0;
    data_in = '0;
    key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    pt0 = 128'h00112233445566778899aabbccddeeff;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 128'(ir), 128'(3'b111));
    chk("reset_ov", 128'(ov), 128'(0));
    chk("reset_busy", 128'(bz), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    start(0, 1'b1, pt0);
    chk("fips_nk4_model", exp_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_out(0, 1'b0);
    drain(0);
    start(1, 1'b1, pt0);
    wait_out(1, 1'b0);
    chk("fips_nk6", de[1], 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    drain(1);
    start(2, 1'b1, pt0);
    wait_out(2, 1'b0);
    chk("fips_nk8", de[2], 128'h8ea2b7ca516745bfeafc49904b496089);
    drain(2);

    start(0, 1'b0, pt0);
    wait_out(0, 1'b1);
    chk("reuse_nk4", de[0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    drain(0);

    start(0, 1'b0, rnd128());
    wait_out(0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      iv[0] = (k == 5 || k == 11);
      key_new = 1'b1;
      data_in = rnd128();
      @(posedge clk); #1;
      chk("hold_ov", 128'(ov[0]), 128'(1));
      chk("hold_data", de[0], exp_ct);
      chk("hold_ready", 128'(ir[0]), 128'(0));
    end
    iv[0] = 1'b0;
    drain(0);
    chk("idle_after_hold", 128'(bz[0]), 128'(0));

    start(0, 1'b0, pt0);
    wait_out(0, 1'b0);
    pt2 = rnd128();
    iv[0] = 1'b1;
    key_new = 1'b0;
    data_in = pt2;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("same_edge_ready", 128'(ir[0]), 128'(1));
    chk("same_edge_busy", 128'(bz[0]), 128'(0));
    chk("same_edge_ov", 128'(ov[0]), 128'(0));
    exp_ct = ref_enc(4, kkey[0], pt2);
    exp_lat = 11;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("accept_next", 128'(bz[0]), 128'(1));
    wait_out(0, 1'b0);
    drain(0);

    start(0, 1'b1, pt0);
    repeat (20) @(posedge clk);
    #1;
    do_reset();
    repeat (60) @(posedge clk);
    #1;
    chk("abort_no_ov", 128'(ov[0]), 128'(0));
    start(0, 1'b0, pt0);
    wait_out(0, 1'b0);
    drain(0);
    start(0, 1'b0, pt0);
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    repeat (15) @(posedge clk);
    #1;
    chk("abort_round_no_ov", 128'(ov[0]), 128'(0));
    start(0, 1'b0, pt0);
    chk("reexp_latency_model", 128'(exp_lat), 128'(51));
    wait_out(0, 1'b0);
    drain(0);

    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 2) == 0) key = {rnd128(), rnd128()};
        start(d, 1'($urandom_range(0, 1)), rnd128());
        wait_out(d, j == 1);
        drain(d);
        chk("others_quiet", 128'(ov), 128'(0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
